// File: rtl/pong_score_ctrl.sv
// Pong game-flow FSM with BCD score, ball count and frame countdown timer.
// Define PONG_HISCORE_EN to build the high-score registers behind hi_dig1:hi_dig0.
module pong_score_ctrl #(
  parameter int BALLS_INIT = 3,
  parameter int TIMER_W    = 7,
  parameter int TIMER_LOAD = 127
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] btn,
  input  logic       refr_tick,
  input  logic       hit,
  input  logic       miss,
  output logic [3:0] dig0,
  output logic [3:0] dig1,
  output logic [1:0] ball,
  output logic       gra_still,
  output logic       show_rule,
  output logic       show_over,
  output logic       timer_up,
  output logic [3:0] hi_dig0,
  output logic [3:0] hi_dig1
);

  localparam logic [1:0]         BALL_RST = 2'(BALLS_INIT);
  localparam logic [TIMER_W-1:0] TMR_LD   = TIMER_W'(TIMER_LOAD);

  typedef enum logic [1:0] {
    NEWGAME,
    PLAY,
    NEWBALL,
    OVER
  } state_t;

  state_t             state, state_n;
  logic [3:0]         dig0_n, dig1_n;
  logic [1:0]         ball_n;
  logic [TIMER_W-1:0] timer, timer_n;
  logic               tmr_load;
  logic               to_over;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= NEWGAME;
      dig0  <= 4'd0;
      dig1  <= 4'd0;
      ball  <= BALL_RST;
      timer <= '0;
    end else begin
      state <= state_n;
      dig0  <= dig0_n;
      dig1  <= dig1_n;
      ball  <= ball_n;
      timer <= timer_n;
    end
  end

  always_comb begin
    state_n  = state;
    dig0_n   = dig0;
    dig1_n   = dig1;
    ball_n   = ball;
    tmr_load = 1'b0;
    to_over  = 1'b0;
    unique case (state)
      NEWGAME: begin
        if (|btn) begin
          state_n = PLAY;
          ball_n  = ball - 2'd1;
        end
      end
      PLAY: begin
        // a miss in the same cycle swallows the hit
        if (miss) begin
          tmr_load = 1'b1;
          if (ball == 2'd0) begin
            state_n = OVER;
            to_over = 1'b1;
          end else begin
            state_n = NEWBALL;
            ball_n  = ball - 2'd1;
          end
        end else if (hit && !(dig1 == 4'd9 && dig0 == 4'd9)) begin
          if (dig0 == 4'd9) begin
            dig0_n = 4'd0;
            dig1_n = dig1 + 4'd1;
          end else begin
            dig0_n = dig0 + 4'd1;
          end
        end
      end
      NEWBALL: begin
        if (timer_up && |btn) state_n = PLAY;
      end
      OVER: begin
        if (timer_up) begin
          state_n = NEWGAME;
          dig0_n  = 4'd0;
          dig1_n  = 4'd0;
          ball_n  = BALL_RST;
        end
      end
      default: state_n = NEWGAME;
    endcase
  end

  always_comb begin
    timer_n = timer;
    if (tmr_load) timer_n = TMR_LD;
    else if (refr_tick && !timer_up) timer_n = timer - 1'b1;
  end

  assign timer_up  = (timer == '0);
  assign gra_still = (state != PLAY);
  assign show_rule = (state == NEWGAME);
  assign show_over = (state == OVER);

`ifdef PONG_HISCORE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_dig0 <= 4'd0;
      hi_dig1 <= 4'd0;
    end else if (to_over && ({dig1, dig0} > {hi_dig1, hi_dig0})) begin
      hi_dig0 <= dig0;
      hi_dig1 <= dig1;
    end
  end
`else
  logic hi_unused;
  assign hi_unused = to_over;
  assign hi_dig0   = 4'd0;
  assign hi_dig1   = 4'd0;
`endif

endmodule

// File: tb/tb_pong_score_ctrl.sv
// Self-checking bench for pong_score_ctrl against a score/phase game model.
// Directed game scenarios followed by a randomized input run.
module tb_pong_score_ctrl;

  logic       clk;
  logic       reset;
  logic [1:0] btn;
  logic       refr_tick;
  logic       hit;
  logic       miss;
  logic [3:0] dig0, dig1, hi_dig0, hi_dig1;
  logic [1:0] ball;
  logic       gra_still, show_rule, show_over, timer_up;

  int vectors;
  int miscompares;

  pong_score_ctrl dut (
    .clk(clk), .reset(reset), .btn(btn), .refr_tick(refr_tick),
    .hit(hit), .miss(miss), .dig0(dig0), .dig1(dig1), .ball(ball),
    .gra_still(gra_still), .show_rule(show_rule), .show_over(show_over),
    .timer_up(timer_up), .hi_dig0(hi_dig0), .hi_dig1(hi_dig1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // game model: phases, score as an integer 0..99, frames left
  typedef enum {G_NEW, G_PLAY, G_WAIT, G_OVER} phase_t;
  phase_t m_ph;
  int m_score, m_ball, m_timer, m_hi;

  logic [21:0] obs;
  assign obs = {dig1, dig0, ball, gra_still, show_rule, show_over,
                timer_up, hi_dig1, hi_dig0};

  localparam logic [21:0] RST_VEC = {8'h00, 2'd3, 4'b1101, 8'h00};

  function automatic void model_reset();
    m_ph = G_NEW; m_score = 0; m_ball = 3; m_timer = 0; m_hi = 0;
  endfunction

  function automatic int hi_exp();
`ifdef PONG_HISCORE_EN
    return m_hi;
`else
    return 0;
`endif
  endfunction

  function automatic logic [21:0] exp_vec();
    int h;
    h = hi_exp();
    return {4'(m_score / 10), 4'(m_score % 10), 2'(m_ball),
            m_ph != G_PLAY, m_ph == G_NEW, m_ph == G_OVER, m_timer == 0,
            4'(h / 10), 4'(h % 10)};
  endfunction

  function automatic void model_step(input logic [1:0] b, input logic h,
                                     input logic m, input logic r);
    int  t0;
    bit  ld;
    t0 = m_timer;
    ld = 0;
    case (m_ph)
      G_NEW:  if (b != 0) begin m_ph = G_PLAY; m_ball--; end
      G_PLAY: begin
        if (m) begin
          ld = 1;
          if (m_ball == 0) begin
            m_ph = G_OVER;
            if (m_score > m_hi) m_hi = m_score;
          end else begin
            m_ball--; m_ph = G_WAIT;
          end
        end else if (h && m_score < 99) m_score++;
      end
      G_WAIT: if (t0 == 0 && b != 0) m_ph = G_PLAY;
      G_OVER: if (t0 == 0) begin m_ph = G_NEW; m_score = 0; m_ball = 3; end
    endcase
    if (ld) m_timer = 127;
    else if (r && t0 > 0) m_timer = t0 - 1;
  endfunction

  task automatic step(input logic [1:0] b, input logic h, input logic m,
                      input logic r);
    @(negedge clk);
    btn = b; hit = h; miss = m; refr_tick = r;
    @(posedge clk);
    model_step(b, h, m, r);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && m_timer != 0; i++) step(2'b00, 0, 0, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    btn = 0; hit = 0; miss = 0; refr_tick = 0;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    btn = 0; hit = 0; miss = 0; refr_tick = 0;
    model_reset();
    #12;
    vectors++;
    if (obs !== RST_VEC) begin
      $display("FAIL reset_state got %h want %h", obs, RST_VEC);
      miscompares++;
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_start();
    step(2'b01, 0, 0, 0);
    vectors++;
    if (obs !== exp_vec() || ball !== 2'd2 || gra_still !== 1'b0) begin
      $display("FAIL start got %h want %h", obs, exp_vec());
      miscompares++;
    end
  endtask

  task automatic test_score();
    repeat (10) step(2'b00, 1, 0, 0);
    vectors++;
    if ({dig1, dig0} !== 8'h10 || obs !== exp_vec()) begin
      $display("FAIL score_10 got %h want %h", obs, exp_vec());
      miscompares++;
    end
    repeat (89) step(2'b00, 1, 0, 0);
    vectors++;
    if ({dig1, dig0} !== 8'h99 || obs !== exp_vec()) begin
      $display("FAIL score_99 got %h want %h", obs, exp_vec());
      miscompares++;
    end
    step(2'b00, 1, 0, 0);
    vectors++;
    if ({dig1, dig0} !== 8'h99 || obs !== exp_vec()) begin
      $display("FAIL score_sat got %h want %h", obs, exp_vec());
      miscompares++;
    end
  endtask

  task automatic test_newball();
    step(2'b00, 0, 1, 0);
    vectors++;
    if (obs !== exp_vec() || ball !== 2'd1 || gra_still !== 1'b1) begin
      $display("FAIL newball_enter got %h want %h", obs, exp_vec());
      miscompares++;
    end
    for (int i = 1; i <= 127; i++) begin
      step(2'b11, 0, 0, 1);
      vectors++;
      if (obs !== exp_vec() || gra_still !== 1'b1) begin
        $display("FAIL newball_hold tick %0d got %h want %h",
                 i, obs, exp_vec());
        miscompares++;
      end
    end
    step(2'b11, 0, 0, 1);
    vectors++;
    if (obs !== exp_vec() || gra_still !== 1'b0) begin
      $display("FAIL newball_resume got %h want %h", obs, exp_vec());
      miscompares++;
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(2'b10, 0, 0, 0);
    repeat (42) step(2'b00, 1, 0, 0);
    step(2'b00, 0, 1, 0);
    repeat (5) step(2'b00, 0, 0, 1);
    vectors++;
    if ({dig1, dig0} !== 8'h42 || ball !== 2'd1 || timer_up !== 1'b0) begin
      $display("FAIL pre_reset got %h want %h", obs, exp_vec());
      miscompares++;
    end
    #1;
    reset = 1'b1;
    hit = 1'b1; btn = 2'b01; refr_tick = 1'b1;
    model_reset();
    #1;
    vectors++;
    if (obs !== RST_VEC) begin
      $display("FAIL async_reset got %h want %h", obs, RST_VEC);
      miscompares++;
    end
    @(posedge clk);
    #1;
    vectors++;
    if (obs !== RST_VEC) begin
      $display("FAIL reset_hold got %h want %h", obs, RST_VEC);
      miscompares++;
    end
    @(negedge clk);
    reset = 1'b0; hit = 0; btn = 0; refr_tick = 0;
  endtask

  task automatic test_over();
    step(2'b01, 0, 0, 0);
    repeat (5) step(2'b00, 1, 0, 0);
    for (int k = 0; k < 2; k++) begin
      step(2'b00, 0, 1, 0);
      drain();
      step(2'b01, 0, 0, 0);
    end
    step(2'b00, 1, 1, 0);
    vectors++;
    if ({dig1, dig0} !== 8'h05 || show_over !== 1'b1 ||
        obs !== exp_vec()) begin
      $display("FAIL over_enter got %h want %h", obs, exp_vec());
      miscompares++;
    end
    for (int i = 1; i <= 127; i++) begin
      step(2'b00, 0, 0, 1);
      vectors++;
      if (obs !== exp_vec() || show_over !== 1'b1) begin
        $display("FAIL over_hold tick %0d got %h want %h",
                 i, obs, exp_vec());
        miscompares++;
      end
    end
    step(2'b00, 0, 0, 0);
    vectors++;
    if ({dig1, dig0} !== 8'h00 || ball !== 2'd3 || show_rule !== 1'b1 ||
        obs !== exp_vec()) begin
      $display("FAIL over_newgame got %h want %h", obs, exp_vec());
      miscompares++;
    end
  endtask

  task automatic play_game(input int pts);
    step(2'b10, 0, 0, 0);
    repeat (pts) step(2'b00, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(2'b00, 0, 1, 0);
      drain();
      if (k < 2) step(2'b01, 0, 0, 0);
    end
    step(2'b00, 0, 0, 0);
  endtask

  task automatic test_hiscore();
    int want [3];
    int pts [3];
    pts = '{17, 9, 23};
`ifdef PONG_HISCORE_EN
    want = '{17, 17, 23};
`else
    want = '{0, 0, 0};
`endif
    do_reset();
    for (int g = 0; g < 3; g++) begin
      play_game(pts[g]);
      vectors++;
      if ({hi_dig1, hi_dig0} !== {4'(want[g] / 10), 4'(want[g] % 10)} ||
          obs !== exp_vec()) begin
        $display("FAIL hiscore game %0d got %h want %0d", g,
                 {hi_dig1, hi_dig0}, want[g]);
        miscompares++;
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] b;
    logic h, m, r;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      b = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      h = ($urandom_range(0, 3) == 0);
      m = ($urandom_range(0, 19) == 0);
      r = ($urandom_range(0, 1) == 0);
      step(b, h, m, r);
      vectors++;
      if (obs !== exp_vec()) begin
        $display("FAIL random cycle %0d got %h want %h", i, obs, exp_vec());
        miscompares++;
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_start();
    test_score();
    test_newball();
    test_async_reset();
    test_over();
    test_hiscore();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
